// File: rtl/inference_sequencer.sv
// Inference sequencer: streams NUM_CLASSES*CLAUSES_PER_CLASS clause words from memory
// into the datapath, drains the pipeline, then captures the per-image prediction.
module inference_sequencer #(
    parameter int unsigned CLAUSE_LEN        = 9,
    parameter int unsigned CLASS_LEN         = 4,
    parameter int unsigned IMAGES            = 8,
    parameter int unsigned NUM_CLASSES       = 10,
    parameter int unsigned CLAUSES_PER_CLASS = 16,
    parameter int unsigned DRAIN_CYCLES      = 3,
    localparam int unsigned N      = NUM_CLASSES * CLAUSES_PER_CLASS,
    localparam int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [IMAGES-1:0]             img_literals,
    output logic                          busy,
    output logic                          done,
    output logic [IMAGES*CLASS_LEN-1:0]   result,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd_en,
    input  logic [CLAUSE_LEN-1:0]         mem_rdata,
    output logic                          dp_start_compute,
    output logic [IMAGES-1:0]             dp_input_literals,
    output logic [CLASS_LEN-1:0]          dp_class_in,
    output logic [CLAUSE_LEN-1:0]         dp_clause_in,
    input  logic [IMAGES*CLASS_LEN-1:0]   dp_predicted_class
);

    localparam int unsigned CL_W  = (CLAUSES_PER_CLASS > 1) ? $clog2(CLAUSES_PER_CLASS) : 1;
    localparam int unsigned DR_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int unsigned RES_W = IMAGES * CLASS_LEN;

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CL_W-1:0]   clause_q, clause_d;
    logic [CLASS_LEN-1:0] class_q, class_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IMAGES-1:0] lit_q, lit_d;
    logic [RES_W-1:0]  result_q, result_d;

    // State and all sequencer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            clause_q <= '0;
            class_q  <= '0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            lit_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            clause_q <= clause_d;
            class_q  <= class_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            lit_q    <= lit_d;
            result_q <= result_d;
        end
    end

    // Next-state and next-output logic; memory address runs one word ahead of the stream index
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clause_d = clause_q;
        class_d  = class_q;
        drain_d  = drain_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_en_d  = 1'b0;
        addr_d   = addr_q;
        lit_d    = lit_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = PRIME;
                    lit_d    = img_literals;
                    busy_d   = 1'b1;
                    rd_en_d  = 1'b1;
                    addr_d   = '0;
                    idx_d    = '0;
                    clause_d = '0;
                    class_d  = '0;
                    drain_d  = '0;
                end
            end
            PRIME: begin
                state_d = STREAM;
                if (N > 1) begin
                    rd_en_d = 1'b1;
                    addr_d  = ADDR_W'(1);
                end
            end
            STREAM: begin
                if (32'(idx_q) == N - 1) begin
                    drain_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = dp_predicted_class;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (32'(idx_q) + 32'd2 <= N - 1) begin
                        rd_en_d = 1'b1;
                        addr_d  = ADDR_W'(32'(idx_q) + 32'd2);
                    end
                    if (32'(clause_q) == CLAUSES_PER_CLASS - 1) begin
                        clause_d = '0;
                        if (32'(class_q) < NUM_CLASSES - 1) begin
                            class_d = class_q + CLASS_LEN'(1);
                        end
                    end else begin
                        clause_d = clause_q + CL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (32'(drain_q) == DRAIN_CYCLES - 1) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = dp_predicted_class;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over every transition and discards the pending capture
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            rd_en_d  = 1'b0;
            result_d = result_q;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign result            = result_q;
    assign mem_addr          = addr_q;
    assign dp_input_literals = lit_q;
    assign dp_class_in       = class_q;
    // Abort must silence the memory and datapath in the same cycle it is raised
    assign mem_rd_en         = rd_en_q & ~abort;
    assign dp_start_compute  = (state_q == STREAM) & ~abort;
    assign dp_clause_in      = (state_q == STREAM) ? mem_rdata : '0;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: table of inference runs plus hand-written abort/reset sequences;
// expected results queued at start and popped when done pulses.
module tb_inference_sequencer;

    localparam int unsigned CLAUSE_LEN  = 9;
    localparam int unsigned CLASS_LEN   = 4;
    localparam int unsigned IMAGES      = 8;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned CPC         = 16;
    localparam int unsigned DRAIN       = 3;
    localparam int          N           = 160;
    localparam int          LATENCY     = 165;
    localparam int          RUN_CYCLES  = 200;

    logic                          clock = 1'b0;
    logic                          reset = 1'b0;
    logic                          start = 1'b0;
    logic                          abort = 1'b0;
    logic [IMAGES-1:0]             img_literals = '0;
    logic                          busy;
    logic                          done;
    logic [IMAGES*CLASS_LEN-1:0]   result;
    logic [7:0]                    mem_addr;
    logic                          mem_rd_en;
    logic [CLAUSE_LEN-1:0]         mem_rdata = '0;
    logic                          dp_start_compute;
    logic [IMAGES-1:0]             dp_input_literals;
    logic [CLASS_LEN-1:0]          dp_class_in;
    logic [CLAUSE_LEN-1:0]         dp_clause_in;
    logic [IMAGES*CLASS_LEN-1:0]   dp_predicted_class = '0;

    inference_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .img_literals       (img_literals),
        .busy               (busy),
        .done               (done),
        .result             (result),
        .mem_addr           (mem_addr),
        .mem_rd_en          (mem_rd_en),
        .mem_rdata          (mem_rdata),
        .dp_start_compute   (dp_start_compute),
        .dp_input_literals  (dp_input_literals),
        .dp_class_in        (dp_class_in),
        .dp_clause_in       (dp_clause_in),
        .dp_predicted_class (dp_predicted_class)
    );

    always #5 clock = ~clock;

    // Clause memory returns its own address, one cycle after the read
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= CLAUSE_LEN'(mem_addr);
    end

    typedef struct {
        logic [7:0]  lit;
        logic [31:0] pred;
        int          abort_k;
        bit          restart;
        int          exp_stream;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        int          latency;
    } exp_t;

    vec_t        vecs[4];
    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] last_result = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(busy), 0);
        check({tag, "_done"},      64'(done), 0);
        check({tag, "_result"},    64'(result), 0);
        check({tag, "_mem_addr"},  64'(mem_addr), 0);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 0);
        check({tag, "_compute"},   64'(dp_start_compute), 0);
        check({tag, "_class"},     64'(dp_class_in), 0);
        check({tag, "_clause"},    64'(dp_clause_in), 0);
        check({tag, "_literals"},  64'(dp_input_literals), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int   stream_cnt = 0;
        int   done_cnt   = 0;
        int   class_err  = 0;
        int   clause_err = 0;
        int   addr_err   = 0;
        int   gap_err    = 0;
        int   busy_err   = 0;
        int   drain_err  = 0;
        int   busy_end;
        exp_t e;
        exp_t got;
        busy_end = (v.abort_k >= 0) ? v.abort_k + 2 : LATENCY;

        tick();
        start              = 1'b1;
        abort              = 1'b0;
        img_literals       = v.lit;
        dp_predicted_class = v.pred;
        if (v.abort_k < 0) begin
            e.result  = v.pred;
            e.latency = LATENCY;
            sb.push_back(e);
        end
        #1;
        for (int c = 1; c < RUN_CYCLES; c++) begin
            tick();
            start        = v.restart && (c == 5 || c == 100);
            img_literals = start ? 8'h3C : ~v.lit;
            abort        = (v.abort_k >= 0) && (c == v.abort_k + 2);
            #1;
            if ((busy === 1'b1) != (c <= busy_end)) busy_err++;
            if (int'(mem_addr) >= N) addr_err++;
            if (dp_start_compute === 1'b1) begin
                if (c != stream_cnt + 2) gap_err++;
                if (dp_class_in !== CLASS_LEN'(stream_cnt / CPC)) class_err++;
                if (dp_clause_in !== CLAUSE_LEN'(stream_cnt)) clause_err++;
                stream_cnt++;
            end
            if (v.abort_k < 0 && c >= N + 2 && c < N + 2 + DRAIN) begin
                if (dp_start_compute !== 1'b0 || mem_rd_en !== 1'b0 ||
                    dp_class_in !== CLASS_LEN'(NUM_CLASSES - 1)) drain_err++;
            end
            if (abort) begin
                check("abort_gate_compute", 64'(dp_start_compute), 0);
                check("abort_gate_rd_en", 64'(mem_rd_en), 0);
            end
            if (v.abort_k >= 0 && c == v.abort_k + 3) begin
                check("abort_busy_next", 64'(busy), 0);
                check("abort_compute_next", 64'(dp_start_compute), 0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                check("done_expected", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("done_latency", 64'(c), 64'(got.latency));
                    check("done_result", 64'(result), 64'(got.result));
                    last_result = got.result;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;

        check("stream_len", 64'(stream_cnt), 64'(v.exp_stream));
        check("stream_gaps", 64'(gap_err), 0);
        check("class_steps", 64'(class_err), 0);
        check("clause_words", 64'(clause_err), 0);
        check("addr_range", 64'(addr_err), 0);
        check("busy_window", 64'(busy_err), 0);
        check("drain_outputs", 64'(drain_err), 0);
        check("done_count", 64'(done_cnt), 64'(v.exp_done));
        check("sb_drained", 64'(sb.size()), 0);
        sb.delete();
        check("result_held", 64'(result), 64'(last_result));
        check("literals_latched", 64'(dp_input_literals), 64'(v.lit));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 32'h9876_5432, -1, 1'b0, N,  1};
        vecs[1] = '{8'h5A, 32'h0123_4567, 40, 1'b0, 40, 0};
        vecs[2] = '{8'h0F, 32'h1111_2222, -1, 1'b1, N,  1};
        vecs[3] = '{8'hFF, 32'h3333_4444, -1, 1'b0, N,  1};

        repeat (2) tick();
        check_all_zero("por");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // start and abort together in IDLE: nothing happens
        tick();
        start = 1'b1;
        abort = 1'b1;
        img_literals = 8'h77;
        #1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("idle_abort_busy", 64'(busy), 0);
        check("idle_abort_rd_en", 64'(mem_rd_en), 0);
        tick();
        check("idle_abort_busy_later", 64'(busy), 0);
        check("idle_abort_compute", 64'(dp_start_compute), 0);
        check("idle_abort_literals", 64'(dp_input_literals), 64'(vecs[3].lit));

        // reset asserted mid-DRAIN clears everything without a clock edge
        tick();
        start = 1'b1;
        img_literals = 8'hC3;
        dp_predicted_class = 32'hDEAD_BEEF;
        #1;
        for (int c = 1; c <= N + 3; c++) begin
            tick();
            start = 1'b0;
            #1;
        end
        check("pre_reset_busy", 64'(busy), 1);
        check("pre_reset_class", 64'(dp_class_in), 64'(NUM_CLASSES - 1));
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        tick();
        reset = 1'b1;
        last_result = '0;

        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter CLAUSE_LEN, default 9, width of one clause word sent to the datapath.
REQ-002 SHALL have parameter CLASS_LEN, default 4, width of the class index.
REQ-003 SHALL have parameter IMAGES, default 8, number of images evaluated in parallel.
REQ-004 SHALL have parameter NUM_CLASSES, default 10, number of classes streamed per inference.
REQ-005 SHALL have parameter CLAUSES_PER_CLASS, default 16, number of clause words per class.
REQ-006 SHALL have parameter DRAIN_CYCLES, default 3, number of idle cycles after the last clause before the result is captured.
REQ-007 SHALL define N = NUM_CLASSES*CLAUSES_PER_CLASS and ADDR_W = clog2(N), minimum 1.
REQ-008 SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port start, input, 1 bit, request to run one inference.
REQ-011 SHALL have port abort, input, 1 bit, synchronous cancel of a running inference.
REQ-012 SHALL have port img_literals, input, IMAGES bits, input literals for this inference.
REQ-013 SHALL have port busy, output, 1 bit, high from PRIME through DONE.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse when result is valid.
REQ-015 SHALL have port result, output, IMAGES*CLASS_LEN bits, the predicted class per image.
REQ-016 SHALL have port mem_addr, output, ADDR_W bits, clause memory read address.
REQ-017 SHALL have port mem_rd_en, output, 1 bit, clause memory read enable.
REQ-018 SHALL have port mem_rdata, input, CLAUSE_LEN bits, clause memory data, valid one cycle after the read.
REQ-019 SHALL have port dp_start_compute, output, 1 bit, datapath compute enable.
REQ-020 SHALL have port dp_input_literals, output, IMAGES bits, literals sent to the datapath.
REQ-021 SHALL have port dp_class_in, output, CLASS_LEN bits, current class index sent to the datapath.
REQ-022 SHALL have port dp_clause_in, output, CLAUSE_LEN bits, current clause word sent to the datapath.
REQ-023 SHALL have port dp_predicted_class, input, IMAGES*CLASS_LEN bits, datapath prediction.

Function
REQ-024 SHALL implement the FSM states IDLE, PRIME, STREAM, DRAIN and DONE.
REQ-025 In IDLE, start=1 with abort=0 SHALL latch img_literals into dp_input_literals and move to PRIME; start SHALL be ignored in every other state.
REQ-026 PRIME SHALL last 1 cycle with mem_rd_en=1 and mem_addr=0, then move to STREAM.
REQ-027 STREAM SHALL last exactly N cycles: in STREAM cycle k, dp_clause_in=mem_rdata (word k), dp_start_compute=1, and dp_class_in=k/CLAUSES_PER_CLASS.
REQ-028 In STREAM cycle k, mem_rd_en=1 and mem_addr=k+1 when k<N-1; mem_rd_en=0 on the last cycle.
REQ-029 The clause counter SHALL wrap from CLAUSES_PER_CLASS-1 to 0 and increment the class counter; the class counter SHALL stop at NUM_CLASSES-1 and never wrap within one run.
REQ-030 DRAIN SHALL last DRAIN_CYCLES cycles with dp_start_compute=0, mem_rd_en=0 and dp_class_in holding NUM_CLASSES-1.
REQ-031 DONE SHALL last 1 cycle: result <= dp_predicted_class, done=1, then return to IDLE.
REQ-032 Latency from the cycle start is sampled to the done cycle SHALL be N+DRAIN_CYCLES+2 cycles (165 at defaults).
REQ-033 result SHALL hold its value until the next DONE or reset.
REQ-034 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, drive dp_start_compute=0 and mem_rd_en=0 immediately, suppress done, and leave result unchanged.
REQ-035 abort=1 together with start in IDLE SHALL take precedence, so start is ignored.
REQ-036 dp_start_compute SHALL be 0 in every state except STREAM.

Reset
REQ-037 reset=0 SHALL asynchronously force state IDLE, counters 0, and busy, done, mem_rd_en and dp_start_compute to 0.
REQ-038 reset=0 SHALL asynchronously force mem_addr, dp_class_in, dp_clause_in, dp_input_literals and result to 0, including mid-run.

Verification
REQ-039 Defaults, start pulse with img_literals=8'hA5: 160 consecutive dp_start_compute cycles, dp_class_in stepping 0..9 every 16 cycles, done exactly 165 cycles after start, result equal to dp_predicted_class.
REQ-040 Memory model returning mem_rdata=address: dp_clause_in equals k in STREAM cycle k for k=0..159, and mem_addr never reaches 160.
REQ-041 start re-pulsed at cycles 5 and 100 of a run: no restart, a single done pulse, dp_input_literals unchanged.
REQ-042 abort at STREAM cycle 40: dp_start_compute=0 and busy=0 by the next cycle, no done pulse, result keeps its previous value; a following start completes normally.
REQ-043 reset asserted in DRAIN: every output reaches 0 without waiting for a clock edge; start after release runs a full 165-cycle inference.
REQ-044 start and abort high together in IDLE: stays in IDLE with busy=0.
